video_window_display: RTL

Parametrised successor to the HDMI display stage. Places a `disp_w` × `disp_h` image window at a programmable offset inside the active frame, draws a programmable-width border around it and fills the remainder with a background colour. Absorbs a configurable read latency from the pixel source. Geometry is double-buffered and swapped only at frame boundaries. Sits between the HDMI timing generator (`pix_x`/`pix_y`/`pix_req`) and the frame-buffer read port (`pixel_req`/`pixel_data`).

---
 rtl/video_pkg.sv | 20 ++
 rtl/pix_delay_line.sv | 30 +++
 rtl/video_window_display.sv | 127 ++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: RGB888 colour constants and the pixel region encoding
// used by the display stages.
package video_pkg;

    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] BLACK  = 24'h000000;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam logic [23:0] PURPLE = 24'h800080;
    localparam logic [23:0] CYAN   = 24'h00FFFF;

    typedef enum logic [1:0] {
        REGION_BG     = 2'd0,
        REGION_BORDER = 2'd1,
        REGION_IMAGE  = 2'd2
    } region_t;

endpackage

// File: rtl/pix_delay_line.sv
// Fixed-length shift register used to keep side-band pixel information aligned
// with a latent data path. Synchronous reset clears every stage.
module pix_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/video_window_display.sv
// Places a bordered image window inside the active frame, fetching image pixels
// from a latent frame-buffer port and filling border/background with constants.
module video_window_display
    import video_pkg::*;
#(
    parameter int          IMAGE_WIDTH  = 11,
    parameter int          RD_LAT       = 1,
    parameter int          BW_WIDTH     = 4,
    parameter logic [23:0] BG_COLOR     = WHITE,
    parameter logic [23:0] BORDER_COLOR = 24'hFF0C00
) (
    input  logic                   pix_clk,
    input  logic                   rst,
    input  logic                   vs_start,
    input  logic [IMAGE_WIDTH-1:0] pix_x,
    input  logic [IMAGE_WIDTH-1:0] pix_y,
    input  logic                   pix_req,
    output logic [23:0]            pix_data,
    input  logic                   cfg_load,
    input  logic [IMAGE_WIDTH-1:0] cfg_win_x,
    input  logic [IMAGE_WIDTH-1:0] cfg_win_y,
    input  logic [IMAGE_WIDTH-1:0] cfg_disp_w,
    input  logic [IMAGE_WIDTH-1:0] cfg_disp_h,
    input  logic [BW_WIDTH-1:0]    cfg_border_w,
    output logic                   cfg_pending,
    output logic                   pixel_req,
    input  logic [23:0]            pixel_data
);

    // Two bits of headroom so that window end plus border can never wrap.
    localparam int CW = IMAGE_WIDTH + 2;

    typedef struct packed {
        logic [IMAGE_WIDTH-1:0] win_x;
        logic [IMAGE_WIDTH-1:0] win_y;
        logic [IMAGE_WIDTH-1:0] disp_w;
        logic [IMAGE_WIDTH-1:0] disp_h;
        logic [BW_WIDTH-1:0]    border_w;
    } geom_t;

    geom_t staging;
    geom_t active;

    // Active geometry only changes at a frame boundary, so a frame never mixes configs.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            staging     <= '0;
            active      <= '0;
            cfg_pending <= 1'b0;
        end else begin
            if (vs_start && cfg_pending) begin
                active <= staging;
            end
            if (cfg_load) begin
                staging     <= '{cfg_win_x, cfg_win_y, cfg_disp_w, cfg_disp_h, cfg_border_w};
                cfg_pending <= 1'b1;
            end else if (vs_start) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    logic [CW-1:0] x, y, bw;
    logic [CW-1:0] img_x0, img_x1, img_y0, img_y1;
    logic [CW-1:0] brd_x0, brd_x1, brd_y0, brd_y1;
    logic          in_image, in_border;
    region_t       region;

    always_comb begin
        x      = CW'(pix_x);
        y      = CW'(pix_y);
        bw     = CW'(active.border_w);
        img_x0 = CW'(active.win_x);
        img_y0 = CW'(active.win_y);
        img_x1 = img_x0 + CW'(active.disp_w);
        img_y1 = img_y0 + CW'(active.disp_h);
        brd_x0 = (img_x0 > bw) ? img_x0 - bw : '0;
        brd_y0 = (img_y0 > bw) ? img_y0 - bw : '0;
        brd_x1 = img_x1 + bw;
        brd_y1 = img_y1 + bw;

        in_image  = (x >= img_x0) && (x < img_x1) && (y >= img_y0) && (y < img_y1);
        in_border = (x >= brd_x0) && (x < brd_x1) && (y >= brd_y0) && (y < brd_y1);

        region = REGION_BG;
        // An empty window also suppresses its border.
        if ((active.disp_w != '0) && (active.disp_h != '0)) begin
            if (in_image) begin
                region = REGION_IMAGE;
            end else if (in_border) begin
                region = REGION_BORDER;
            end
        end
    end

    assign pixel_req = pix_req && (region == REGION_IMAGE);

    logic [2:0] dly_out;
    logic       dly_req;
    region_t    dly_region;

    pix_delay_line #(
        .DEPTH (RD_LAT),
        .WIDTH (3)
    ) u_delay (
        .pix_clk (pix_clk),
        .rst     (rst),
        .din     ({pix_req, region}),
        .dout    (dly_out)
    );

    assign dly_req    = dly_out[2];
    assign dly_region = region_t'(dly_out[1:0]);

    always_ff @(posedge pix_clk) begin
        if (rst || !dly_req) begin
            pix_data <= '0;
        end else begin
            case (dly_region)
                REGION_IMAGE:  pix_data <= pixel_data;
                REGION_BORDER: pix_data <= BORDER_COLOR;
                default:       pix_data <= BG_COLOR;
            endcase
        end
    end

endmodule
